// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg: register map, CTRL bit indices and reset values shared by the
// SPI-facing PWM register block.
package spi_pwm_pkg;

  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_PRESCALE = 1;
  localparam int unsigned ADDR_PERIOD   = 2;
  localparam int unsigned ADDR_DUTY     = 3;
  localparam int unsigned ADDR_STATUS   = 4;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_POL = 1;
  localparam int unsigned CTRL_IE  = 2;

  localparam int unsigned RST_CTRL     = 'h00;
  localparam int unsigned RST_PRESCALE = 'h00;
  localparam int unsigned RST_PERIOD   = 'hFF;
  localparam int unsigned RST_DUTY     = 'h80;

endpackage

// File: rtl/spi_pwm_regs_if.sv
// spi_pwm_regs_if: completed-write and readback signals between the SPI slave
// (master modport) and the PWM register bank (slave modport).
interface spi_pwm_regs_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7
);
  logic              wr_toggle;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_toggle, output wr_addr, output wr_data,
                  output rd_addr, input rd_data);
  modport slave  (input wr_toggle, input wr_addr, input wr_data,
                  input rd_addr, output rd_data);
endinterface

// File: rtl/spi_pwm_regs_toggle_sync.sv
// toggle_sync: brings a toggle-encoded event from a foreign clock domain into
// clk through SYNC_STAGES flops and emits a one-clk pulse per toggle.
module toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tog_in,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Synchroniser chain followed by the edge-detect flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] ^ edge_q;
endmodule

// File: rtl/spi_pwm_regs.sv
// spi_pwm_regs: PWM control register bank written from the SPI domain via a
// toggle handshake, with double-buffered period/duty and combinational readback.
// Optional STATUS flag and interrupt output are enabled by defining PWM_IRQ_EN.
module spi_pwm_regs
  import spi_pwm_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_pwm_regs_if.slave        bus,
  output logic                 pwm_out,
  output logic                 period_end,
  output logic                 irq
);
  logic              wr_stb;
  logic              ctrl_en;
  logic              ctrl_pol;
  logic              ctrl_ie;
  logic [DATA_W-1:0] prescale;
  logic [DATA_W-1:0] period;
  logic [DATA_W-1:0] duty;
  logic [DATA_W-1:0] per_sh;
  logic [DATA_W-1:0] duty_sh;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] psc_cnt;
  logic              tick;
  logic              wrap;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk    (clk),
    .rst    (rst),
    .tog_in (bus.wr_toggle),
    .pulse  (wr_stb)
  );

  assign tick = ctrl_en && (psc_cnt == prescale);
  assign wrap = tick && (cnt == per_sh);

  // Register bank writes; address/data are stable around the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en  <= RST_CTRL[CTRL_EN];
      ctrl_pol <= RST_CTRL[CTRL_POL];
`ifdef PWM_IRQ_EN
      ctrl_ie  <= RST_CTRL[CTRL_IE];
`endif
      prescale <= DATA_W'(RST_PRESCALE);
      period   <= DATA_W'(RST_PERIOD);
      duty     <= DATA_W'(RST_DUTY);
    end else if (wr_stb) begin
      case (bus.wr_addr)
        ADDR_W'(ADDR_CTRL): begin
          ctrl_en  <= bus.wr_data[CTRL_EN];
          ctrl_pol <= bus.wr_data[CTRL_POL];
`ifdef PWM_IRQ_EN
          ctrl_ie  <= bus.wr_data[CTRL_IE];
`endif
        end
        ADDR_W'(ADDR_PRESCALE): prescale <= bus.wr_data;
        ADDR_W'(ADDR_PERIOD):   period   <= bus.wr_data;
        ADDR_W'(ADDR_DUTY):     duty     <= bus.wr_data;
        default: ;
      endcase
    end
  end

  // Prescaler; a counter above a freshly lowered PRESCALE restarts at 0.
  always_ff @(posedge clk) begin
    if (rst || !ctrl_en) begin
      psc_cnt <= '0;
    end else if (psc_cnt >= prescale) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= psc_cnt + 1'b1;
    end
  end

  // PWM counter and shadow registers; shadows follow live values while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      per_sh     <= DATA_W'(RST_PERIOD);
      duty_sh    <= DATA_W'(RST_DUTY);
      period_end <= 1'b0;
    end else if (!ctrl_en) begin
      cnt        <= '0;
      per_sh     <= period;
      duty_sh    <= duty;
      period_end <= 1'b0;
    end else begin
      period_end <= wrap;
      if (wrap) begin
        cnt     <= '0;
        per_sh  <= period;
        duty_sh <= duty;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered PWM output with polarity; idles at POL when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else if (ctrl_en) begin
      pwm_out <= (cnt < duty_sh) ^ ctrl_pol;
    end else begin
      pwm_out <= ctrl_pol;
    end
  end

`ifdef PWM_IRQ_EN
  logic status_flag;
  logic status_clr;

  assign status_clr = wr_stb && (bus.wr_addr == ADDR_W'(ADDR_STATUS));

  // Sticky period flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_flag <= 1'b0;
    end else if (period_end) begin
      status_flag <= 1'b1;
    end else if (status_clr) begin
      status_flag <= 1'b0;
    end
  end

  // Registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= status_flag & ctrl_ie;
    end
  end
`else
  assign ctrl_ie = 1'b0;
  assign irq     = 1'b0;
`endif

  // Combinational readback; unmapped addresses read 0.
  always_comb begin
    bus.rd_data = '0;
    case (bus.rd_addr)
      ADDR_W'(ADDR_CTRL): begin
        bus.rd_data[CTRL_EN]  = ctrl_en;
        bus.rd_data[CTRL_POL] = ctrl_pol;
        bus.rd_data[CTRL_IE]  = ctrl_ie;
      end
      ADDR_W'(ADDR_PRESCALE): bus.rd_data = prescale;
      ADDR_W'(ADDR_PERIOD):   bus.rd_data = period;
      ADDR_W'(ADDR_DUTY):     bus.rd_data = duty;
`ifdef PWM_IRQ_EN
      ADDR_W'(ADDR_STATUS):   bus.rd_data[0] = status_flag;
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_spi_pwm_regs.sv
// tb_spi_pwm_regs: directed bench for spi_pwm_regs; covers write latency,
// register map, PWM waveform with double-buffered duty, boundary duty/period,
// polarity, disable, prescaler, reset and (with PWM_IRQ_EN) the interrupt flag.
module tb_spi_pwm_regs;
  logic clk = 1'b0;
  logic rst;
  logic pwm_out;
  logic period_end;
  logic irq;

  spi_pwm_regs_if #(.DATA_W(8), .ADDR_W(7)) bus ();

  spi_pwm_regs #(.DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pwm;
    logic pe;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   k      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle; returns just after the falling edge.
  task automatic step();
    @(negedge clk);
    k++;
  endtask

  // Completed SPI write: toggle with stable addr/data, register live after 3 edges.
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    bus.wr_addr   = a;
    bus.wr_data   = d;
    bus.wr_toggle = ~bus.wr_toggle;
    repeat (3) step();
  endtask

  task automatic rd_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
    bus.rd_addr = a;
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  // PRESCALE=0 waveform: sample kk after enable is counter phase kk-1.
  task automatic run_sb(input int n, input int len, input int d_old, input int d_new, input int k_sw);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      int kk;
      int d;
      kk    = k + i;
      d     = (kk <= k_sw) ? d_old : d_new;
      e.pwm = (((kk - 1) % len) < d);
      e.pe  = ((kk % len) == 0);
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      step();
      e = sb.pop_front();
      check($sformatf("pwm_k%0d", k), pwm_out, e.pwm);
      check($sformatf("pe_k%0d", k), period_end, e.pe);
    end
  endtask

  task automatic const_check(input string tag, input int n, input logic exp);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, pwm_out, exp);
    end
  endtask

  initial begin
    int highs;
    int pes;
    rst           = 1'b1;
    bus.wr_toggle = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_addr   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    rd_check("rst_ctrl", 7'd0, 8'h00);
    rd_check("rst_psc", 7'd1, 8'h00);
    rd_check("rst_per", 7'd2, 8'hFF);
    rd_check("rst_duty", 7'd3, 8'h80);
    check("rst_pwm", pwm_out, 1'b0);
    check("rst_pe", period_end, 1'b0);
    check("rst_irq", irq, 1'b0);

    // Write latency: PERIOD changes on the 3rd edge, not before
    bus.rd_addr   = 7'd2;
    bus.wr_addr   = 7'd2;
    bus.wr_data   = 8'h09;
    bus.wr_toggle = ~bus.wr_toggle;
    @(posedge clk); #1 check("lat_edge1", bus.rd_data, 8'hFF);
    @(posedge clk); #1 check("lat_edge2", bus.rd_data, 8'hFF);
    @(posedge clk); #1 check("lat_edge3", bus.rd_data, 8'h09);
    @(negedge clk);

    // Unmapped writes ignored, reads 0
    wr(7'd5, 8'h55);
    rd_check("unmap_rd5", 7'd5, 8'h00);
    rd_check("unmap_per", 7'd2, 8'h09);
    wr(7'd4, 8'h55);
    rd_check("rd4_idle", 7'd4, 8'h00);

    // CTRL upper bits read 0; IE only exists with the feature
    wr(7'd0, 8'hFC);
`ifdef PWM_IRQ_EN
    rd_check("ctrl_mask", 7'd0, 8'h04);
`else
    rd_check("ctrl_mask", 7'd0, 8'h00);
`endif

    // PERIOD=9 DUTY=3: 3 high / 7 low, period_end every 10
    wr(7'd3, 8'd3);
    wr(7'd0, 8'h01);
    k = 0;
    run_sb(20, 10, 3, 3, 0);
    // DUTY=7 lands mid-period (k=23); new duty from the wrap at k=30
    wr(7'd3, 8'd7);
    run_sb(17, 10, 3, 7, 30);

    // DUTY=0 constant low, DUTY>PERIOD constant high
    wr(7'd3, 8'd0);
    repeat (12) step();
    const_check("duty0", 10, 1'b0);
    wr(7'd3, 8'd12);
    repeat (12) step();
    const_check("duty12", 10, 1'b1);

    // POL inverts both extremes
    wr(7'd0, 8'h03);
    repeat (2) step();
    const_check("pol_duty12", 10, 1'b0);
    wr(7'd3, 8'd0);
    repeat (12) step();
    const_check("pol_duty0", 10, 1'b1);

    // EN=0 idles at POL with no period_end
    wr(7'd0, 8'h02);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("dis_pwm", pwm_out, 1'b1);
      check("dis_pe", period_end, 1'b0);
    end
    wr(7'd0, 8'h00);
    step();
    check("dis_pol0", pwm_out, 1'b0);

    // PERIOD=0: wraps every tick, output high when DUTY!=0
    wr(7'd2, 8'd0);
    wr(7'd3, 8'd3);
    wr(7'd0, 8'h01);
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("per0_pwm", pwm_out, 1'b1);
      check("per0_pe", period_end, 1'b1);
    end

    // PRESCALE=1: 20-clk period, 6 high clks per period
    wr(7'd0, 8'h00);
    wr(7'd2, 8'd9);
    wr(7'd1, 8'd1);
    wr(7'd0, 8'h01);
    highs = 0;
    pes   = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      highs += int'(pwm_out);
      pes   += int'(period_end);
    end
    check("psc_highs", highs, 12);
    check("psc_wraps", pes, 2);

`ifdef PWM_IRQ_EN
    wr(7'd0, 8'h00);
    wr(7'd1, 8'd0);
    wr(7'd4, 8'h00);
    wr(7'd0, 8'h05);
    k = 0;
    while (k < 5) step();
    check("irq_pre", irq, 1'b0);
    while (k < 12) step();
    check("irq_set", irq, 1'b1);
    step();
    wr(7'd4, 8'h00);
    step();
    check("irq_clr", irq, 1'b0);
    while (k < 33) step();
    check("irq_reset2", irq, 1'b1);
    while (k < 38) step();
    wr(7'd4, 8'h00);
    step();
    check("irq_set_wins", irq, 1'b1);
    rd_check("status_set_wins", 7'd4, 8'h01);
`else
    wr(7'd0, 8'h05);
    repeat (15) step();
    check("irq_tied0", irq, 1'b0);
`endif

    // Reset mid-period returns everything to reset values
    wr(7'd0, 8'h01);
    repeat (4) step();
    rst           = 1'b1;
    bus.wr_toggle = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    rd_check("rst2_ctrl", 7'd0, 8'h00);
    rd_check("rst2_psc", 7'd1, 8'h00);
    rd_check("rst2_per", 7'd2, 8'hFF);
    rd_check("rst2_duty", 7'd3, 8'h80);
    check("rst2_pwm", pwm_out, 1'b0);
    check("rst2_pe", period_end, 1'b0);
    check("rst2_irq", irq, 1'b0);
    const_check("rst2_idle", 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
